code_seq_checker: RTL and testbench
===================================

CODE_SEQ_CHECKER -- requirements
Module: code_seq_checker

Interface
REQ-001 SHALL have parameter ERR_W, default 8, meaning width of the saturating error counter.
REQ-002 SHALL have parameter SMP_W, default 5, meaning width of the saturating sample counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  sample strobe; code is sampled on a clk edge where en=1.
REQ-006 SHALL have port code  input  4  code word under test, bit 3 = MSB.
REQ-007 SHALL have port mode  input  3  code selector: 0 binary, 1 BCD, 2 Gray, 3 Aiken, 4 Stibitz, 5-7 illegal.
REQ-008 SHALL have port value  output  4  registered decoded binary value of the last sample.
REQ-009 SHALL have port valid  output  1  one-cycle pulse, one clk after each sampled en.
REQ-010 SHALL have port err  output  1  one-cycle pulse coincident with valid when the sample failed checking.
REQ-011 SHALL have port err_cnt  output  ERR_W  errors since reset, saturating.
REQ-012 SHALL have port smp_cnt  output  SMP_W  samples since reset, saturating.
REQ-013 SHALL have port done  output  1  level; high while in state DONE.

Function
REQ-014 SHALL decode: binary = code; BCD = code, legal only for 0-9; Gray = prefix-XOR of code from MSB down; Aiken 0000-0100 -> 0-4 and 1011-1111 -> 5-9, all else illegal; Stibitz = code-3, legal only for 0011-1100.
REQ-015 SHALL use terminal value 15 for binary and Gray, 9 for BCD, Aiken, Stibitz.
REQ-016 SHALL implement states IDLE, TRACK, DONE, held in a registered state variable.
REQ-017 SHALL latch mode on the first en in IDLE and ignore mode changes until rst.
REQ-018 SHALL, in IDLE on en, require decoded value 0; go to TRACK (DONE if terminal were 0, never true); flag err otherwise but still go to TRACK.
REQ-019 SHALL, in TRACK on en, require decoded value = expected (previous legal value + 1); flag err otherwise.
REQ-020 SHALL, when a legal sample equals the terminal value in TRACK, go to DONE.
REQ-021 SHALL, in DONE on en, require decoded value = terminal (generators saturate); flag err otherwise; remain in DONE.
REQ-022 SHALL, after a legal but wrong sample, resynchronise: expected = that value + 1; after an illegal code, keep expected and previous value unchanged.
REQ-023 SHALL flag err for any illegal code word or illegal latched mode; on illegal code value SHALL output 0.
REQ-024 SHALL present value/valid/err exactly one clk after the sampling edge; en=0 cycles produce valid=0, err=0, no state change.
REQ-025 SHALL increment err_cnt on each err pulse, holding at 2^ERR_W-1; smp_cnt likewise per sample, holding at 2^SMP_W-1.
REQ-026 SHALL accept en on consecutive cycles with no stall.

Reset
REQ-027 SHALL on rst=1 at a clk edge set state IDLE, value 0, valid 0, err 0, err_cnt 0, smp_cnt 0, done 0, expected 0, latched mode 0.
REQ-028 SHALL give rst priority over a simultaneous en; that sample is discarded and produces no valid pulse.
REQ-029 SHALL allow rst mid-sequence; the next en is treated as a first sample in IDLE.

Configuration
REQ-030 SHALL compile Aiken and Stibitz decoding only when macro CODE_SEQ_CHECKER_AIKEN_STIBITZ_EN is defined.
REQ-031 SHALL, without CODE_SEQ_CHECKER_AIKEN_STIBITZ_EN, treat modes 3 and 4 as illegal (every sample err=1, value 0); modes 0-2 unchanged.

Verification
REQ-032 SHALL test binary: mode 0, codes 0..15 then 15 x3 on consecutive en -> 19 valid pulses, err never, done high from the cycle after code 15, smp_cnt 19, err_cnt 0.
REQ-033 SHALL test Gray: mode 2, 0000,0001,0011,0010,0110 -> values 0,1,2,3,4, no err.
REQ-034 SHALL test BCD fault: mode 1, 0,1,2,1010,3 -> value 0 with err on 1010, then 3 accepted without err, err_cnt 1.
REQ-035 SHALL test Stibitz with macro: mode 4, 0011,0100,0110,0111 -> values 0,1,3,4; err only on 0110; 0111 accepted after resync; without macro all four err, err_cnt 4.
REQ-036 SHALL test reset: binary at value 7, assert rst with en=1 -> no valid, all outputs 0; next en with code 0000 -> value 0, no err.
REQ-037 SHALL test saturation: ERR_W=2, five erroneous samples -> err_cnt stops at 3.

Source files
------------

// File: rtl/code_seq_checker.sv
// code_seq_checker: checks a 4-bit counting sequence in binary/BCD/Gray codes, with saturating error and sample counters.
// Aiken and Stibitz decoding are compiled only when CODE_SEQ_CHECKER_AIKEN_STIBITZ_EN is defined.
module code_seq_checker #(
  parameter int ERR_W = 8,
  parameter int SMP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       code,
  input  logic [2:0]       mode,
  output logic [3:0]       value,
  output logic             valid,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [SMP_W-1:0] smp_cnt,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] mode_q, mode_d, m;
  logic [3:0] exp_q, exp_d, value_q, value_d, raw, dec, term;
  logic legal, ok, valid_q, valid_d, err_q, err_d, done_q, done_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [SMP_W-1:0] smp_cnt_q, smp_cnt_d;
  always_comb begin
    m = (state_q == IDLE) ? mode : mode_q;
    legal = 1'b0;
    raw = code;
    case (m)
      3'd0: legal = 1'b1;
      3'd1: legal = code <= 4'd9;
      3'd2: begin
        legal = 1'b1;
        raw = {code[3], ^code[3:2], ^code[3:1], ^code};
      end
`ifdef CODE_SEQ_CHECKER_AIKEN_STIBITZ_EN
      3'd3: begin
        legal = code <= 4'd4 || code >= 4'd11;
        raw = (code <= 4'd4) ? code : code - 4'd6;
      end
      3'd4: begin
        legal = code >= 4'd3 && code <= 4'd12;
        raw = code - 4'd3;
      end
`endif
      default: legal = 1'b0;
    endcase
    dec = legal ? raw : 4'd0;
    term = (m == 3'd0 || m == 3'd2) ? 4'd15 : 4'd9;
    // IDLE is only entered through reset, so exp_q is 0 there
    ok = legal && dec == ((state_q == DONE) ? term : exp_q);
    state_d = state_q;
    mode_d = mode_q;
    exp_d = exp_q;
    value_d = value_q;
    valid_d = en;
    err_d = 1'b0;
    if (en) begin
      value_d = dec;
      err_d = !ok;
      if (state_q == IDLE) begin
        mode_d = mode;
        state_d = TRACK;
      end
      if (legal && state_q != DONE) exp_d = dec + 4'd1;
      if (legal && state_q == TRACK && dec == term) state_d = DONE;
    end
    done_d = state_d == DONE;
    err_cnt_d = err_cnt_q + ERR_W'(err_d && err_cnt_q != '1);
    smp_cnt_d = smp_cnt_q + SMP_W'(en && smp_cnt_q != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 3'd0;
      exp_q <= 4'd0;
      value_q <= 4'd0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      exp_q <= exp_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q <= err_d;
      done_q <= done_d;
      err_cnt_q <= err_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end
  assign value = value_q;
  assign valid = valid_q;
  assign err = err_q;
  assign done = done_q;
  assign err_cnt = err_cnt_q;
  assign smp_cnt = smp_cnt_q;
endmodule

// File: tb/tb_code_seq_checker.sv
// tb_code_seq_checker: directed and random checks of code_seq_checker against a behavioural sequence model.
module tb_code_seq_checker;
`ifdef CODE_SEQ_CHECKER_AIKEN_STIBITZ_EN
  localparam bit AS_EN = 1'b1;
`else
  localparam bit AS_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [3:0] code = 4'd0;
  logic [2:0] mode = 3'd0;
  logic [3:0] value, s_value;
  logic valid, err, done, s_valid, s_err, s_done;
  logic [7:0] err_cnt;
  logic [1:0] s_err_cnt;
  logic [4:0] smp_cnt, s_smp_cnt;
  int n_cmp = 0, n_bad = 0;
  int ph, m_mode, m_exp, m_val, m_valid, m_err, m_errc, m_errc2, m_smpc;

  code_seq_checker dut (.clk(clk), .rst(rst), .en(en), .code(code), .mode(mode),
    .value(value), .valid(valid), .err(err), .err_cnt(err_cnt), .smp_cnt(smp_cnt), .done(done));
  code_seq_checker #(.ERR_W(2)) dut_sat (.clk(clk), .rst(rst), .en(en), .code(code), .mode(mode),
    .value(s_value), .valid(s_valid), .err(s_err), .err_cnt(s_err_cnt), .smp_cnt(s_smp_cnt), .done(s_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // returns -1 for an illegal code word or mode
  function automatic int ref_decode(int md, int c);
    case (md)
      0: return c;
      1: return (c <= 9) ? c : -1;
      2: return (c ^ (c >> 1) ^ (c >> 2) ^ (c >> 3)) & 15;
      3: return !AS_EN ? -1 : (c <= 4) ? c : (c >= 11) ? c - 6 : -1;
      4: return (AS_EN && c >= 3 && c <= 12) ? c - 3 : -1;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    ph = 0; m_mode = 0; m_exp = 0; m_val = 0; m_valid = 0; m_err = 0;
    m_errc = 0; m_errc2 = 0; m_smpc = 0;
  endtask

  task automatic cycle(input bit r, input bit e, input int c, input int md);
    int d, t, want, em;
    rst = r; en = e; code = c[3:0]; mode = md[2:0];
    @(posedge clk);
    m_valid = 0; m_err = 0;
    if (r) model_reset();
    else if (e) begin
      em = (ph == 0) ? md : m_mode;
      if (ph == 0) m_mode = md;
      d = ref_decode(em, c);
      t = (em == 0 || em == 2) ? 15 : 9;
      want = (ph == 2) ? t : m_exp;
      m_valid = 1;
      m_err = (d < 0 || d != want) ? 1 : 0;
      m_val = (d < 0) ? 0 : d;
      if (d >= 0 && ph != 2) m_exp = (d + 1) % 16;
      if (ph == 0) ph = 1;
      else if (ph == 1 && d == t) ph = 2;
      if (m_smpc < 31) m_smpc++;
      if (m_err && m_errc < 255) m_errc++;
      if (m_err && m_errc2 < 3) m_errc2++;
    end
    #1;
    chk("valid", valid, m_valid);
    chk("err", err, m_err);
    chk("value", value, m_val);
    chk("done", done, ph == 2);
    chk("err_cnt", err_cnt, m_errc);
    chk("smp_cnt", smp_cnt, m_smpc);
    chk("err_cnt_w2", s_err_cnt, m_errc2);
  endtask

  task automatic run_seq(input int md, input int codes[$]);
    foreach (codes[i]) cycle(0, 1, codes[i], md);
  endtask

  initial begin
    model_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 1, 5, 1);
    // binary 0..15 then saturated terminal
    for (int i = 0; i < 16; i++) cycle(0, 1, i, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 15, 0);
    chk("bin_smp19", smp_cnt, 19);
    chk("bin_done", done, 1);
    cycle(0, 0, 3, 0);
    cycle(0, 1, 14, 0);
    // Gray
    cycle(1, 0, 0, 0);
    run_seq(2, '{0, 1, 3, 2, 6});
    chk("gray_val4", value, 4);
    // BCD with an illegal word mid-sequence
    cycle(1, 0, 0, 0);
    run_seq(1, '{0, 1, 2, 10, 3});
    chk("bcd_errc1", err_cnt, 1);
    // Stibitz (all illegal without the Aiken/Stibitz build)
    cycle(1, 0, 0, 0);
    run_seq(4, '{3, 4, 6, 7});
    chk("stib_errc", err_cnt, AS_EN ? 1 : 4);
    // Aiken
    cycle(1, 0, 0, 0);
    run_seq(3, '{0, 1, 2, 3, 4, 11, 12, 7, 13, 14, 15, 15});
    // reset mid-sequence with simultaneous en
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, i, 0);
    chk("rst_pre_val7", value, 7);
    cycle(1, 1, 8, 0);
    chk("rst_no_valid", valid, 0);
    cycle(0, 1, 0, 0);
    chk("rst_first_ok", err, 0);
    // error counter saturation
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 5, 0);
    chk("sat_w2", s_err_cnt, 3);
    // illegal mode and mode change ignored after latch
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 6);
    cycle(0, 1, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 7);
    // random traffic, biased toward following the sequence
    for (int i = 0; i < 600; i++) begin
      int c;
      c = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : m_exp;
      if (m_mode == 2 && ph != 0) c = m_exp ^ (m_exp >> 1);
      cycle($urandom_range(0, 50) == 0, $urandom_range(0, 3) != 0, c, $urandom_range(0, 7));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
